// File: rtl/imul_prod_accum.sv
// Product accumulator: sums each group of NTERMS 32-bit products modulo 2^32 and
// hands the sum to a one-entry output buffer so the next group can start immediately.
module imul_prod_accum #(
    parameter int unsigned NTERMS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [31:0] istream_msg,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [31:0] ostream_msg
);

    localparam int unsigned CW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NTERMS - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [31:0]   acc;
    logic [CW-1:0] cnt;
    logic [31:0]   out_reg;
    logic [0:0]    out_full;

    logic        last_term;
    logic        in_fire;
    logic        out_fire;
    logic [31:0] sum;

    assign last_term = (cnt == LAST_CNT);
    assign sum       = acc + istream_msg;

    // Only the final term needs the buffer, so only it can stall; no path from ostream_rdy.
    assign istream_rdy = !last_term || (out_full == EMPTY);
    assign ostream_val = (out_full == FULL);
    assign ostream_msg = out_reg;

    assign in_fire  = istream_val && istream_rdy;
    assign out_fire = ostream_val && ostream_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (last_term) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A final-term load needs EMPTY and a transfer needs FULL, so they never coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg  <= '0;
            out_full <= EMPTY;
        end else if (in_fire && last_term) begin
            out_reg  <= sum;
            out_full <= FULL;
        end else if (out_fire) begin
            out_full <= EMPTY;
        end
    end

endmodule

// File: tb/tb_imul_prod_accum.sv
// Directed bench for imul_prod_accum: one instance with NTERMS=4 and one with NTERMS=2.
module tb_imul_prod_accum;

    logic        clk;
    logic        reset;

    logic        iv4, ir4, ov4, or4;
    logic [31:0] im4, om4;
    logic        iv2, ir2, ov2, or2;
    logic [31:0] im2, om2;

    int n_tests;
    int n_fail;

    imul_prod_accum #(.NTERMS(4)) u_acc4 (
        .clk         (clk),
        .reset       (reset),
        .istream_val (iv4),
        .istream_rdy (ir4),
        .istream_msg (im4),
        .ostream_val (ov4),
        .ostream_rdy (or4),
        .ostream_msg (om4)
    );

    imul_prod_accum #(.NTERMS(2)) u_acc2 (
        .clk         (clk),
        .reset       (reset),
        .istream_val (iv2),
        .istream_rdy (ir2),
        .istream_msg (im2),
        .ostream_val (ov2),
        .ostream_rdy (or2),
        .ostream_msg (om2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product to the NTERMS=4 instance; returns #1 after the accepting edge.
    task automatic push4(input logic [31:0] m);
        int n;
        n = 0;
        iv4 = 1'b1;
        im4 = m;
        while (!ir4 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push4_timeout", 32'd0, 32'd1);
        tick();
        iv4 = 1'b0;
    endtask

    task automatic push2(input logic [31:0] m);
        int n;
        n = 0;
        iv2 = 1'b1;
        im2 = m;
        while (!ir2 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push2_timeout", 32'd0, 32'd1);
        tick();
        iv2 = 1'b0;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] half;
    logic        have_half;
    logic [31:0] exp_v;
    int          sent;
    int          beats;
    int          cyc;
    logic        ifire;
    logic        ofire;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        iv4 = 1'b0; im4 = '0; or4 = 1'b1;
        iv2 = 1'b0; im2 = '0; or2 = 1'b1;

        // Reset, then idle
        tick();
        check("rst_ov4", {31'd0, ov4}, 32'd0);
        check("rst_om4", om4, 32'd0);
        check("rst_ov2", {31'd0, ov2}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_ir4", {31'd0, ir4}, 32'd1);
        check("idle_ir2", {31'd0, ir2}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ov4", {31'd0, ov4}, 32'd0);
        end
        check("idle_om4", om4, 32'd0);

        // Single group 3+5+7+11
        push4(32'd3);
        push4(32'd5);
        push4(32'd7);
        check("grp_no_early", {31'd0, ov4}, 32'd0);
        push4(32'd11);
        check("grp_val", {31'd0, ov4}, 32'd1);
        check("grp_msg", om4, 32'h1A);
        tick();
        check("grp_one_beat", {31'd0, ov4}, 32'd0);
        check("grp_msg_hold", om4, 32'h1A);

        // Wrap-around and negative products
        push4(32'hFFFF_FFFF);
        push4(32'h0000_0002);
        push4(32'hFFFF_FFFE);
        push4(32'h0000_0005);
        check("wrap_val", {31'd0, ov4}, 32'd1);
        check("wrap_msg", om4, 32'h0000_0004);
        tick();
        check("wrap_drain", {31'd0, ov4}, 32'd0);

        // Back-pressure on the NTERMS=2 instance
        or2 = 1'b0;
        push2(32'd1);
        push2(32'd2);
        check("bp_val", {31'd0, ov2}, 32'd1);
        check("bp_msg", om2, 32'd3);
        check("bp_rdy_nonfinal", {31'd0, ir2}, 32'd1);
        push2(32'd10);
        check("bp_rdy_final", {31'd0, ir2}, 32'd0);
        iv2 = 1'b1;
        im2 = 32'd20;
        tick();
        tick();
        tick();
        check("bp_stall_rdy", {31'd0, ir2}, 32'd0);
        check("bp_stall_val", {31'd0, ov2}, 32'd1);
        check("bp_stall_msg", om2, 32'd3);
        or2 = 1'b1;
        tick();
        check("bp_drained", {31'd0, ov2}, 32'd0);
        check("bp_rdy_back", {31'd0, ir2}, 32'd1);
        tick();
        iv2 = 1'b0;
        check("bp_next_val", {31'd0, ov2}, 32'd1);
        check("bp_next_msg", om2, 32'd30);
        tick();
        check("bp_next_drain", {31'd0, ov2}, 32'd0);

        // Random streaming, pairwise sums
        have_half = 1'b0;
        half = '0;
        sent = 0;
        beats = 0;
        cyc = 0;
        while ((sent < 200 || exp_q.size() != 0) && cyc < 5000) begin
            if (!iv2 && sent < 200 && $urandom_range(1, 0) == 1) begin
                iv2 = 1'b1;
                im2 = $urandom;
            end
            or2 = ($urandom_range(1, 0) == 1);
            ifire = iv2 && ir2;
            ofire = ov2 && or2;
            if (ofire) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("stream_extra_beat", om2, 32'hDEAD_BEEF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("stream_sum", om2, exp_v);
                end
            end
            if (ifire) begin
                sent++;
                if (have_half) begin
                    exp_q.push_back(half + im2);
                    have_half = 1'b0;
                end else begin
                    half = im2;
                    have_half = 1'b1;
                end
            end
            tick();
            cyc++;
            if (ifire) iv2 = 1'b0;
        end
        check("stream_beats", beats, 32'd100);
        check("stream_pending", exp_q.size(), 32'd0);
        or2 = 1'b1;

        // Asynchronous reset mid-operation with a full buffer
        or4 = 1'b0;
        push4(32'd1);
        push4(32'd1);
        push4(32'd1);
        push4(32'd1);
        check("mid_full", {31'd0, ov4}, 32'd1);
        push4(32'd100);
        push4(32'd200);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_val", {31'd0, ov4}, 32'd0);
        check("mid_rst_msg", om4, 32'd0);
        #1;
        reset = 1'b1;
        or4 = 1'b1;
        tick();
        check("mid_rst_rdy", {31'd0, ir4}, 32'd1);
        push4(32'd1);
        push4(32'd1);
        push4(32'd1);
        push4(32'd1);
        check("mid_after_val", {31'd0, ov4}, 32'd1);
        check("mid_after_msg", om4, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
